ctrl_fsm: RTL and testbench

Multi-cycle control state machine that drives the ALU and the surrounding datapath of the RV32I core. It decodes the latched instruction, sequences fetch/decode/execute/memory/writeback over several cycles, and emits the 4-bit ALU op plus all datapath enables. It consumes the ALU `zero` flag to resolve branches, and handshakes with a single shared instruction/data memory port.

---
 rtl/ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle RV32I control state machine.
// Sequences fetch/decode/execute/memory/writeback and drives ALU op and datapath selects.
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_op,
    output logic        illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_MEM_WB, S_ALU_WB, S_BRANCH,
        S_JALR_ADDR, S_JAL, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       r_legal;
    logic       take;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // funct7 = 0100000 only encodes SUB and SRA
    assign r_legal = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) &&
                      (funct3 == 3'b000 || funct3 == 3'b101));

    function automatic logic [3:0] alu_dec(input logic [2:0] f3,
                                           input logic       sub,
                                           input logic       sra);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = sra ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 3'b000;
        result_src = 2'b00;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        take       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                unique case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:     state_d = S_EXEC_R;
                    OP_I:     state_d = S_EXEC_I;
                    OP_BR:    state_d = S_BRANCH;
                    OP_JALR:  state_d = S_JALR_ADDR;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: state_d = S_AUIPC;
                    OP_JAL: begin
                        imm_src = 3'b100;
                        state_d = S_JAL;
                    end
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = alu_dec(funct3, funct7[5], funct7[5]);
                state_d   = r_legal ? S_ALU_WB : S_ILLEGAL;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = alu_dec(funct3, 1'b0, funct7[5]);
                state_d   = S_ALU_WB;
            end
            S_MEM_ADDR: begin
                // opcode bit 5 separates stores from loads
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = opcode[5] ? 3'b001 : 3'b000;
                state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                rf_we      = 1'b1;
                state_d    = S_FETCH;
            end
            S_ALU_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                state_d   = S_FETCH;
                case (funct3)
                    3'b000: begin alu_op = ALU_SUB;  take = zero;  end
                    3'b001: begin alu_op = ALU_SUB;  take = !zero; end
                    3'b100: begin alu_op = ALU_SLT;  take = !zero; end
                    3'b101: begin alu_op = ALU_SLT;  take = zero;  end
                    3'b110: begin alu_op = ALU_SLTU; take = !zero; end
                    3'b111: begin alu_op = ALU_SLTU; take = zero;  end
                    default: state_d = S_ILLEGAL;
                endcase
                pc_we = take;
            end
            S_JALR_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                pc_we     = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b011;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b011;
                state_d   = S_ALU_WB;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_d = S_FETCH;
        endcase
        // reset aborts whatever is in flight
        if (rst) begin
            state_d = S_FETCH;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed vector table plus randomized instruction stream
// checked against a per-instruction phase-list model.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_src, ir_we, pc_we, rf_we, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic [3:0]  alu_op;

    ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_we(ir_we), .pc_we(pc_we),
        .rf_we(rf_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .result_src(result_src), .alu_op(alu_op),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [13:0] M_AD = 14'h2000;
    localparam logic [13:0] M_A  = 14'h1800;
    localparam logic [13:0] M_B  = 14'h0600;
    localparam logic [13:0] M_IM = 14'h01C0;
    localparam logic [13:0] M_RS = 14'h0030;
    localparam logic [13:0] M_OP = 14'h000F;

    localparam logic [5:0] E_REQ = 6'b100000;
    localparam logic [5:0] E_WE  = 6'b010000;
    localparam logic [5:0] E_IR  = 6'b001000;
    localparam logic [5:0] E_PC  = 6'b000100;
    localparam logic [5:0] E_RF  = 6'b000010;
    localparam logic [5:0] E_ILL = 6'b000001;

    localparam int F_REQ = 1,  F_WE = 2,   F_PC = 4,  F_RF = 8;
    localparam int F_ILL = 16, F_FET = 32, F_WAIT = 64;
    localparam int F_BR = 128, F_RST = 256;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;
    localparam int K_BADOP = 9, K_BADR = 10, K_BADBR = 11;

    function automatic logic [13:0] sd(input logic v);
        return {v, 13'b0};
    endfunction
    function automatic logic [13:0] sa(input logic [1:0] v);
        return {1'b0, v, 11'b0};
    endfunction
    function automatic logic [13:0] sb(input logic [1:0] v);
        return {3'b0, v, 9'b0};
    endfunction
    function automatic logic [13:0] si(input logic [2:0] v);
        return {5'b0, v, 6'b0};
    endfunction
    function automatic logic [13:0] sr(input logic [1:0] v);
        return {8'b0, v, 4'b0};
    endfunction
    function automatic logic [13:0] so(input logic [3:0] v);
        return {10'b0, v};
    endfunction

    task automatic cyc(input logic r, input logic [31:0] ins,
                       input logic z, input logic rd,
                       input logic [5:0] en, input logic [13:0] val,
                       input logic [13:0] msk, input string nm);
        logic [5:0]  got_en;
        logic [13:0] got_sel;
        rst       = r;
        instr     = ins;
        zero      = z;
        mem_ready = rd;
        @(negedge clk);
        got_en  = {mem_req, mem_we, ir_we, pc_we, rf_we, illegal};
        got_sel = {addr_src, alu_src_a, alu_src_b, imm_src,
                   result_src, alu_op};
        n_chk++;
        if (got_en !== en || (got_sel & msk) !== (val & msk))
            $display("FAIL %s t=%0t instr=%h: got en=%b sel=%h, want en=%b sel=%h (mask %h)",
                     nm, $time, ins, got_en, got_sel & msk, en, val & msk, msk);
        else
            n_pass++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [31:0] ins;
        logic        z;
        logic        rd;
        logic [5:0]  en;
        logic [13:0] val;
        logic [13:0] msk;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    task automatic row(input logic r, input logic [31:0] ins,
                       input logic z, input logic rd,
                       input logic [5:0] en, input logic [13:0] val,
                       input logic [13:0] msk, input string nm);
        vec_t v;
        v.r = r; v.ins = ins; v.z = z; v.rd = rd;
        v.en = en; v.val = val; v.msk = msk; v.nm = nm;
        tbl.push_back(v);
    endtask

    typedef struct {
        int          fl;
        logic [13:0] val;
        logic [13:0] msk;
    } ph_t;
    ph_t q[$];

    typedef struct {
        logic [31:0] bits;
        int          kind;
        logic [3:0]  op;
        logic        inv;
        string       name;
    } ins_t;

    logic [6:0] r_f7 [10];
    logic [2:0] r_f3 [10];
    logic [3:0] r_op [10];
    logic [2:0] i_f3 [9];
    logic [6:0] i_f7 [9];
    logic       i_sh [9];
    logic [3:0] i_op [9];
    logic [2:0] b_f3 [6];
    logic [3:0] b_op [6];
    logic       b_inv [6];
    logic [2:0] ld_f3 [5];

    task automatic push(input int fl, input logic [13:0] v,
                        input logic [13:0] m);
        ph_t p;
        p.fl = fl; p.val = v; p.msk = m;
        q.push_back(p);
    endtask

    task automatic push_wb();
        push(F_RF, sr(2'b00), M_RS);
    endtask

    task automatic push_tail();
        for (int i = 0; i < 3; i++) push(F_ILL, 14'd0, 14'd0);
        push(F_RST, 14'd0, 14'd0);
    endtask

    task automatic push_jal();
        push(F_PC, sa(2'b01) | sb(2'b10) | sr(2'b00) | so(4'b0000),
             M_A | M_B | M_RS | M_OP);
    endtask

    // expected cycle-by-cycle behaviour of one instruction
    task automatic build(input ins_t s);
        q.delete();
        push(F_REQ | F_FET | F_WAIT,
             sd(1'b0) | sa(2'b00) | sb(2'b10) | sr(2'b10) | so(4'b0000),
             M_AD | M_A | M_B | M_RS | M_OP);
        push(0, sa(2'b01) | sb(2'b01) |
                si(s.kind == K_JAL ? 3'd4 : 3'd2) | so(4'b0000),
             M_A | M_B | M_IM | M_OP);
        case (s.kind)
            K_R: begin
                push(0, sa(2'b10) | sb(2'b00) | so(s.op), M_A | M_B | M_OP);
                push_wb();
            end
            K_I: begin
                push(0, sa(2'b10) | sb(2'b01) | si(3'd0) | so(s.op),
                     M_A | M_B | M_IM | M_OP);
                push_wb();
            end
            K_LD: begin
                push(0, sa(2'b10) | sb(2'b01) | si(3'd0) | so(4'b0000),
                     M_A | M_B | M_IM | M_OP);
                push(F_REQ | F_WAIT, sd(1'b1), M_AD);
                push(F_RF, sr(2'b01), M_RS);
            end
            K_ST: begin
                push(0, sa(2'b10) | sb(2'b01) | si(3'd1) | so(4'b0000),
                     M_A | M_B | M_IM | M_OP);
                push(F_REQ | F_WE | F_WAIT, sd(1'b1), M_AD);
            end
            K_BR:
                push(F_BR, sa(2'b10) | sb(2'b00) | sr(2'b00) | so(s.op),
                     M_A | M_B | M_RS | M_OP);
            K_JAL: begin
                push_jal();
                push_wb();
            end
            K_JALR: begin
                push(0, sa(2'b10) | sb(2'b01) | si(3'd0) | so(4'b0000),
                     M_A | M_B | M_IM | M_OP);
                push_jal();
                push_wb();
            end
            K_LUI: begin
                push(0, sa(2'b11) | sb(2'b01) | si(3'd3) | so(4'b0000),
                     M_A | M_B | M_IM | M_OP);
                push_wb();
            end
            K_AUIPC: begin
                push(0, sa(2'b01) | sb(2'b01) | si(3'd3) | so(4'b0000),
                     M_A | M_B | M_IM | M_OP);
                push_wb();
            end
            K_BADR: begin
                push(0, sa(2'b10) | sb(2'b00), M_A | M_B);
                push_tail();
            end
            K_BADBR: begin
                push(0, sa(2'b10) | sb(2'b00), M_A | M_B);
                push_tail();
            end
            default: push_tail();
        endcase
    endtask

    function automatic logic legal_opc(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                         7'b0010111};
    endfunction

    function automatic ins_t gen();
        ins_t        s;
        int          c;
        int          k;
        logic [31:0] r;
        logic [6:0]  o;
        logic [6:0]  hi;
        logic [2:0]  f3;
        c = $urandom_range(0, 99);
        r = $urandom;
        s.inv = 1'b0;
        s.op = 4'b0000;
        if (c < 12) begin
            k = $urandom_range(0, 9);
            s.bits = {r_f7[k], r[24:15], r_f3[k], r[11:7], 7'b0110011};
            s.kind = K_R; s.op = r_op[k]; s.name = "rnd_r";
        end else if (c < 24) begin
            k = $urandom_range(0, 8);
            hi = i_sh[k] ? i_f7[k] : r[31:25];
            s.bits = {hi, r[24:15], i_f3[k], r[11:7], 7'b0010011};
            s.kind = K_I; s.op = i_op[k]; s.name = "rnd_i";
        end else if (c < 34) begin
            k = $urandom_range(0, 4);
            s.bits = {r[31:15], ld_f3[k], r[11:7], 7'b0000011};
            s.kind = K_LD; s.name = "rnd_load";
        end else if (c < 44) begin
            f3 = 3'($urandom_range(0, 2));
            s.bits = {r[31:15], f3, r[11:7], 7'b0100011};
            s.kind = K_ST; s.name = "rnd_store";
        end else if (c < 60) begin
            k = $urandom_range(0, 5);
            s.bits = {r[31:15], b_f3[k], r[11:7], 7'b1100011};
            s.kind = K_BR; s.op = b_op[k]; s.inv = b_inv[k];
            s.name = "rnd_branch";
        end else if (c < 68) begin
            s.bits = {r[31:7], 7'b1101111};
            s.kind = K_JAL; s.name = "rnd_jal";
        end else if (c < 76) begin
            s.bits = {r[31:15], 3'b000, r[11:7], 7'b1100111};
            s.kind = K_JALR; s.name = "rnd_jalr";
        end else if (c < 84) begin
            s.bits = {r[31:7], 7'b0110111};
            s.kind = K_LUI; s.name = "rnd_lui";
        end else if (c < 92) begin
            s.bits = {r[31:7], 7'b0010111};
            s.kind = K_AUIPC; s.name = "rnd_auipc";
        end else if (c < 95) begin
            o = r[6:0];
            if (legal_opc(o)) o = 7'b1111111;
            s.bits = {r[31:7], o};
            s.kind = K_BADOP; s.name = "rnd_badop";
        end else if (c < 98) begin
            if (r[0]) begin
                hi = 7'b0100000;
                f3 = r[13] ? 3'b001 : {1'b1, r[12], 1'b0};
                if (f3 == 3'b100 && r[14]) f3 = 3'b111;
            end else begin
                hi = {1'b1, r[30:25]};
                f3 = r[14:12];
            end
            s.bits = {hi, r[24:15], f3, r[11:7], 7'b0110011};
            s.kind = K_BADR; s.name = "rnd_bad_r";
        end else begin
            s.bits = {r[31:15], 2'b01, r[12], r[11:7], 7'b1100011};
            s.kind = K_BADBR; s.name = "rnd_bad_branch";
        end
        return s;
    endfunction

    task automatic run(input ins_t s);
        int         idx;
        int         guard;
        logic       rnow, rd, z, tk, fet;
        logic [5:0] en;
        ph_t        p;
        idx = 0;
        guard = 0;
        build(s);
        while (idx < q.size()) begin
            p    = q[idx];
            rd   = ($urandom_range(0, 2) != 0);
            z    = 1'($urandom_range(0, 1));
            rnow = ((p.fl & F_RST) != 0) || ($urandom_range(0, 59) == 0);
            tk   = s.inv ? !z : z;
            fet  = ((p.fl & F_FET) != 0) && rd;
            en   = 6'd0;
            if (!rnow)
                en = {(p.fl & F_REQ) != 0, (p.fl & F_WE) != 0, fet,
                      ((p.fl & F_PC) != 0) || fet ||
                      (((p.fl & F_BR) != 0) && tk),
                      (p.fl & F_RF) != 0, (p.fl & F_ILL) != 0};
            cyc(rnow, s.bits, z, rd, en, p.val,
                rnow ? 14'd0 : p.msk, s.name);
            if (rnow) break;
            if (!(((p.fl & F_WAIT) != 0) && !rd)) idx++;
            guard++;
            if (guard > 200) begin
                n_chk++;
                $display("FAIL %s cycle budget: got %0d cycles, want <= 200",
                         s.name, guard);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before 2ms");
        $fatal(1);
    end

    initial begin
        logic [13:0] fs, fm, ds, dm;
        logic [31:0] add_i, sub_i, bne_i, lw_i, ill_i, sw_i;
        r_f7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00,
                 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        r_f3 = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        r_op = '{4'b0000, 4'b0001, 4'b1000, 4'b0010, 4'b0011,
                 4'b0110, 4'b1001, 4'b1010, 4'b0101, 4'b0100};
        i_f3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
        i_f7 = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                 7'h00, 7'h00, 7'h20};
        i_sh = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        i_op = '{4'b0000, 4'b0010, 4'b0011, 4'b0110, 4'b0101,
                 4'b0100, 4'b1000, 4'b1001, 4'b1010};
        b_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        b_op  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0011};
        b_inv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        fs = sd(1'b0) | sa(2'b00) | sb(2'b10) | sr(2'b10) | so(4'b0000);
        fm = M_AD | M_A | M_B | M_RS | M_OP;
        ds = sa(2'b01) | sb(2'b01) | si(3'd2) | so(4'b0000);
        dm = M_A | M_B | M_IM | M_OP;
        add_i = 32'h002081B3;
        sub_i = 32'h402081B3;
        bne_i = 32'h00209463;
        lw_i  = 32'h0000A183;
        ill_i = 32'h0000007F;
        sw_i  = 32'h0020A023;

        row(1'b1, 32'd0, 1'b0, 1'b1, 6'd0, 14'd0, 14'd0, "reset");
        row(1'b0, add_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "add_fetch");
        row(1'b0, add_i, 1'b0, 1'b0, 6'd0, ds, dm, "add_decode");
        row(1'b0, add_i, 1'b0, 1'b0, 6'd0, sa(2'b10) | sb(2'b00) | so(4'b0000),
            M_A | M_B | M_OP, "add_exec");
        row(1'b0, add_i, 1'b0, 1'b0, E_RF, sr(2'b00), M_RS, "add_wb");
        row(1'b0, sub_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "sub_fetch");
        row(1'b0, sub_i, 1'b0, 1'b0, 6'd0, ds, dm, "sub_decode");
        row(1'b0, sub_i, 1'b0, 1'b0, 6'd0, sa(2'b10) | sb(2'b00) | so(4'b0001),
            M_A | M_B | M_OP, "sub_exec");
        row(1'b0, sub_i, 1'b0, 1'b0, E_RF, sr(2'b00), M_RS, "sub_wb");
        row(1'b0, bne_i, 1'b1, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "bne_fetch");
        row(1'b0, bne_i, 1'b1, 1'b0, 6'd0, ds, dm, "bne_decode");
        row(1'b0, bne_i, 1'b1, 1'b0, 6'd0,
            sa(2'b10) | sb(2'b00) | sr(2'b00) | so(4'b0001),
            M_A | M_B | M_RS | M_OP, "bne_not_taken");
        row(1'b0, bne_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "bne_fetch2");
        row(1'b0, bne_i, 1'b0, 1'b0, 6'd0, ds, dm, "bne_decode2");
        row(1'b0, bne_i, 1'b0, 1'b0, E_PC,
            sa(2'b10) | sb(2'b00) | sr(2'b00) | so(4'b0001),
            M_A | M_B | M_RS | M_OP, "bne_taken");
        row(1'b0, lw_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "lw_fetch");
        row(1'b0, lw_i, 1'b0, 1'b0, 6'd0, ds, dm, "lw_decode");
        row(1'b0, lw_i, 1'b0, 1'b0, 6'd0,
            sa(2'b10) | sb(2'b01) | si(3'd0) | so(4'b0000),
            M_A | M_B | M_IM | M_OP, "lw_addr");
        for (int i = 0; i < 3; i++)
            row(1'b0, lw_i, 1'b0, 1'b0, E_REQ, sd(1'b1), M_AD, "lw_wait");
        row(1'b0, lw_i, 1'b0, 1'b1, E_REQ, sd(1'b1), M_AD, "lw_ready");
        row(1'b0, lw_i, 1'b0, 1'b0, E_RF, sr(2'b01), M_RS, "lw_wb");
        row(1'b0, ill_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "ill_fetch");
        row(1'b0, ill_i, 1'b0, 1'b0, 6'd0, ds, dm, "ill_decode");
        for (int i = 0; i < 10; i++)
            row(1'b0, ill_i, 1'(i % 2), 1'b1, E_ILL, 14'd0, 14'd0, "ill_hold");
        row(1'b1, ill_i, 1'b0, 1'b1, 6'd0, 14'd0, 14'd0, "ill_rst");
        row(1'b0, ill_i, 1'b0, 1'b0, E_REQ, fs, fm, "ill_refetch");
        row(1'b0, sw_i, 1'b0, 1'b1, E_REQ | E_IR | E_PC, fs, fm, "sw_fetch");
        row(1'b0, sw_i, 1'b0, 1'b0, 6'd0, ds, dm, "sw_decode");
        row(1'b0, sw_i, 1'b0, 1'b0, 6'd0,
            sa(2'b10) | sb(2'b01) | si(3'd1) | so(4'b0000),
            M_A | M_B | M_IM | M_OP, "sw_addr");
        for (int i = 0; i < 2; i++)
            row(1'b0, sw_i, 1'b0, 1'b0, E_REQ | E_WE, sd(1'b1), M_AD, "sw_wait");
        row(1'b1, sw_i, 1'b0, 1'b1, 6'd0, 14'd0, 14'd0, "sw_rst");
        row(1'b0, sw_i, 1'b0, 1'b0, E_REQ, fs, fm, "sw_refetch");

        rst = 1'b1;
        instr = 32'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i].r, tbl[i].ins, tbl[i].z, tbl[i].rd,
                tbl[i].en, tbl[i].val, tbl[i].msk, tbl[i].nm);

        for (int n = 0; n < 400; n++)
            run(gen());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
